// File: rtl/poly_small_sqnorm_if.sv
// Bus bundle for poly_small_sqnorm: start/enable, the f/g coefficient arrays
// and the squared-norm result.
interface poly_small_sqnorm_if #(
    parameter int logn = 9
);
    localparam int N = 1 << logn;

    logic              ena;
    logic              fg_valid;
    logic signed [7:0] f [N];
    logic signed [7:0] g [N];
    logic              busy;
    logic              done;
    logic [31:0]       sqnorm;
    logic              pass;

    modport master (
        output ena, fg_valid, f, g,
        input  busy, done, sqnorm, pass
    );

    modport slave (
        input  ena, fg_valid, f, g,
        output busy, done, sqnorm, pass
    );
endinterface

// File: rtl/poly_small_sqnorm.sv
// Squared norm of the small key polynomials (f, g) and check against the keygen bound.
// Optional per-coefficient range check: define POLY_SMALL_SQNORM_RANGE_CHECK_EN.
module poly_small_sqnorm #(
    parameter int logn        = 9,
    parameter int BOUND       = 16823,
    parameter int MAX_FG_BITS = 6
) (
    input logic                 clk,
    input logic                 rst,
    poly_small_sqnorm_if.slave  bus
);
    localparam int N      = 1 << logn;
    localparam int COEF_W = 8;
    localparam int DATA_W = 32;
    localparam int LIM    = (1 << (MAX_FG_BITS - 1)) - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, CHECK} state_t;

    state_t              state;
    state_t              state_next;
    logic [logn-1:0]     idx;
    logic [DATA_W-1:0]   acc;
    logic [15:0]         sum_p0;
    logic                last;
    logic                done_r;
    logic                pass_r;
    logic [DATA_W-1:0]   sqnorm_r;
`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
    logic                range_bad;
`endif

    // Exact square; (-128)^2 = 16384 still fits in 15 bits.
    function automatic logic [14:0] square(input logic signed [COEF_W-1:0] c);
        logic signed [15:0] w;
        logic signed [15:0] p;
        w = 16'(c);
        p = w * w;
        return p[14:0];
    endfunction

    function automatic logic in_range(input logic signed [COEF_W-1:0] c);
        int v;
        v = int'(c);
        return (v >= -LIM) && (v <= LIM);
    endfunction

    // Stage p0: per-index f^2 + g^2, combinational from the current index
    always_comb begin
        sum_p0 = {1'b0, square(bus.f[idx])} + {1'b0, square(bus.g[idx])};
        last   = &idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!bus.ena) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.fg_valid) state_next = ACCUM;
                ACCUM:   if (last) state_next = CHECK;
                CHECK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Stage p1: accumulate, then publish result and acceptance flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            idx      <= '0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            sqnorm_r <= '0;
`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
            range_bad <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (!bus.ena) begin
                acc <= '0;
                idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.fg_valid) begin
                            acc <= '0;
                            idx <= '0;
`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
                            range_bad <= 1'b0;
`endif
                        end
                    end
                    ACCUM: begin
                        acc <= acc + DATA_W'(sum_p0);
                        idx <= idx + logn'(1);
`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
                        range_bad <= range_bad | ~in_range(bus.f[idx]) | ~in_range(bus.g[idx]);
`endif
                    end
                    CHECK: begin
                        sqnorm_r <= acc;
`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
                        pass_r   <= (acc < DATA_W'(BOUND)) && !range_bad;
`else
                        pass_r   <= (acc < DATA_W'(BOUND));
`endif
                        done_r   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy   = (state == ACCUM) || (state == CHECK);
    assign bus.done   = done_r;
    assign bus.sqnorm = sqnorm_r;
    assign bus.pass   = pass_r;
endmodule

// File: tb/tb_poly_small_sqnorm.sv
// Scoreboard bench for poly_small_sqnorm: directed (f, g) vectors with
// hand-computed squared norms, bound straddles, busy-start, reset and enable aborts.
module tb_poly_small_sqnorm;
    localparam int LOGN = 9;
    localparam int N    = 1 << LOGN;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] sq;
        logic        ps;
        int          at;
    } exp_t;
    exp_t q[$];

    poly_small_sqnorm_if #(.logn(LOGN)) bus ();

    poly_small_sqnorm #(.logn(LOGN), .BOUND(16823), .MAX_FG_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef POLY_SMALL_SQNORM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sqnorm", bus.sqnorm, e.sq);
                chk("pass", 32'(bus.pass), 32'(e.ps));
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("busy_in_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic clear_fg();
        for (int i = 0; i < N; i++) begin
            bus.f[i] = 8'sd0;
            bus.g[i] = 8'sd0;
        end
    endtask

    task automatic fill_fg(input logic signed [7:0] fv, input logic signed [7:0] gv);
        for (int i = 0; i < N; i++) begin
            bus.f[i] = fv;
            bus.g[i] = gv;
        end
    endtask

    // Pulse fg_valid for one cycle; optionally register the expected outcome.
    task automatic start_run(input logic [31:0] sq, input logic ps, input bit push);
        int t0;
        @(posedge clk); #1;
        bus.fg_valid = 1'b1;
        t0 = cyc + 1;
        if (push) q.push_back('{sq: sq, ps: ps, at: t0 + N + 1});
        @(posedge clk); #1;
        bus.fg_valid = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            k++;
            if (k > N + 20) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.fg_valid = 1'b0;
        clear_fg();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sqnorm", bus.sqnorm, 32'd0);
        chk("reset_pass", 32'(bus.pass), 32'd0);
        rst = 1'b0;
        bus.ena = 1'b1;

        // All zeros
        start_run(32'd0, 1'b1, 1'b1); wait_done();
        // Bound straddle
        fill_fg(8'sd4, 8'sd4);
        start_run(32'd16384, 1'b1, 1'b1); wait_done();
        fill_fg(8'sd4, 8'sd5);
        start_run(32'd20992, 1'b0, 1'b1); wait_done();
        // Extremes
        clear_fg();
        bus.f[7] = -8'sd128; bus.g[7] = 8'sd127;
        start_run(32'd32513, 1'b0, 1'b1); wait_done();
        // Exact bound edge: 16384 + 400 + 36 + 3 = 16823, then one less
        clear_fg();
        bus.f[0] = -8'sd128; bus.f[1] = 8'sd20; bus.f[2] = 8'sd6;
        bus.g[0] = 8'sd1; bus.g[1] = 8'sd1; bus.g[2] = 8'sd1;
        start_run(32'd16823, 1'b0, 1'b1); wait_done();
        bus.g[2] = 8'sd0;
        start_run(32'd16822, !RC, 1'b1); wait_done();
        // Range check
        clear_fg();
        bus.f[3] = 8'sd32;
        start_run(32'd1024, !RC, 1'b1); wait_done();
        bus.f[3] = -8'sd31;
        start_run(32'd961, 1'b1, 1'b1); wait_done();

        // Start while busy is ignored
        clear_fg();
        bus.f[0] = 8'sd10; bus.g[1] = -8'sd3;
        start_run(32'd109, 1'b1, 1'b1);
        repeat (98) @(posedge clk);
        #1 bus.fg_valid = 1'b1;
        @(posedge clk); #1 bus.fg_valid = 1'b0;
        wait_done();
        // Start in the done cycle is accepted
        fill_fg(8'sd1, -8'sd1);
        bus.fg_valid = 1'b1;
        q.push_back('{sq: 32'd1024, ps: 1'b1, at: cyc + 1 + N + 1});
        @(posedge clk); #1 bus.fg_valid = 1'b0;
        wait_done();

        // Reset abort
        fill_fg(8'sd4, 8'sd5);
        start_run(32'd0, 1'b0, 1'b0);
        repeat (199) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_rst_busy", 32'(bus.busy), 32'd0);
        chk("abort_rst_done", 32'(bus.done), 32'd0);
        chk("abort_rst_sqnorm", bus.sqnorm, 32'd0);
        chk("abort_rst_pass", 32'(bus.pass), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (N + 20) @(posedge clk);
        clear_fg();
        bus.f[5] = 8'sd100; bus.g[9] = -8'sd100;
        start_run(32'd20000, 1'b0, 1'b1); wait_done();

        // Enable abort: prior result (20000, 0) must hold
        fill_fg(8'sd2, 8'sd2);
        start_run(32'd0, 1'b0, 1'b0);
        repeat (199) @(posedge clk);
        #1 bus.ena = 1'b0;
        @(posedge clk); #1;
        chk("abort_ena_busy", 32'(bus.busy), 32'd0);
        chk("abort_ena_sqnorm", bus.sqnorm, 32'd20000);
        chk("abort_ena_pass", 32'(bus.pass), 32'd0);
        bus.ena = 1'b1;
        repeat (N + 20) @(posedge clk);
        clear_fg();
        bus.f[0] = 8'sd2; bus.g[0] = 8'sd3;
        start_run(32'd13, 1'b1, 1'b1); wait_done();

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
